rv_multicycle_ctrl: RTL and testbench
=====================================

# rv_multicycle_ctrl

- Multi-cycle control unit for the RISC-V core: FSM that fetches, decodes and sequences each instruction through the shared datapath.
- Successor to the single-cycle combinational decoder:
  - adds an instruction-memory/data-memory handshake with parametrised timeout;
  - decodes OR/SRL and the full branch set;
  - adds per-state enables for the PC and instruction register, plus illegal-opcode and bus-error halts.
- Sits between the instruction register/memory arbiter and the register file, ALU, immediate extender and PC mux.

## Interface
Parameters:
- CALU_W, 3, ALU control width (encodings below occupy 3 LSBs; extra MSBs driven 0)
- WAIT_W, 4, memory wait-counter width
- TIMEOUT, 15, cycles without MEM_ACK before bus-error halt (must be < 2^WAIT_W)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- OP_CODE  in  7  instruction[6:0]
- FUNCT_3  in  3  instruction[14:12]
- FUNCT_7  in  7  instruction[31:25]
- MEM_ACK  in  1  memory completes current request this cycle
- MEM_REQ  out  1  memory request (fetch or data)
- IRW  out  1  instruction register write
- PCW  out  1  PC write
- CRF  out  1  register-file write enable
- CEU  out  3  immediate type: I=000, S=001, B=010, U=011, J=100
- CALU  out  CALU_W  ALU op: ADD=000, SUB=001, AND=010, XOR=011, SLL=100, SRA=101, OR=110, SRL=111
- CDM  out  1  data-memory write enable
- PCS  out  2  next PC: 00 PC+4, 01 branch target, 10 rs1+imm, 11 PC+imm
- DWS  out  2  write-back source: 00 ALU, 01 memory, 10 PC+4, 11 immediate
- ALUS1  out  1  ALU A: 0 rs1, 1 PC
- ALUS2  out  1  ALU B: 0 rs2, 1 immediate
- BS  out  1  branch instruction active
- OS  out  1  invert compare result
- ILLEGAL  out  1  sticky, unsupported encoding decoded
- BUS_ERR  out  1  sticky, memory timeout
- STATE  out  3  current state, for debug

## Operation
- **States:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- **Reset state:** FETCH.
- **FETCH:** MEM_REQ=1. On MEM_ACK: IRW=1 that cycle, next DECODE.
- **DECODE:**
  - Samples OP_CODE/FUNCT_3/FUNCT_7 into internal registers; all later states use only the latched copies.
  - Supported: OP-IMM (0010011: ADDI/ANDI/ORI/XORI/SLLI/SRLI/SRAI), OP (0110011: ADD/SUB/AND/OR/XOR/SLL/SRL/SRA), LW (0000011, f3=010), SW (0100011, f3=010), LUI, JAL, JALR (f3=000), BEQ/BNE/BLT/BGE.
  - Anything else, including FUNCT_7 not 0000000/0100000 where relevant: ILLEGAL=1, next HALT.
- **EXEC:**
  - ALU controls driven.
  - OP/OP-IMM → WB. LW/SW → MEM, with CALU=ADD, ALUS2=1, CEU=I or S.
  - Branch: BS=1, OS=f3[0], CEU=B, PCS=01, PCW=1, next FETCH. The datapath gates the PC mux on the compare result.
  - LUI, JAL, JALR → WB.
- **MEM:** MEM_REQ=1, CDM=1 for SW. On MEM_ACK: LW → WB; SW → PCW=1, PCS=00, next FETCH.
- **WB:**
  - CRF=1, PCW=1, next FETCH.
  - PCS: 11 for JAL, 10 for JALR, else 00.
  - DWS: 01 LW, 10 JAL/JALR, 11 LUI, else 00.
- **Wait counter:**
  - Cleared on entry to FETCH/MEM; increments each cycle MEM_REQ=1 without MEM_ACK.
  - At count==TIMEOUT without ack: BUS_ERR=1, next HALT.
- **HALT:** all enables 0; exit only by RST.
- **Control outputs:** Moore function of state and latched fields. In states where a control field is unused it is 0.

## Timing
- **Reset:** during RST=0, every output is 0 and STATE=0. MEM_REQ goes high the first cycle after release.
- **MEM_ACK:** sampled on the rising edge while MEM_REQ=1 and may arrive in the same cycle as the request. MEM_ACK while MEM_REQ=0 is ignored.
- **Latency with zero-wait memory:**
  - ALU/LUI/JAL/JALR: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch: 3 cycles.
- **Memory waits:** each wait cycle adds 1.
- **Timeout boundary:** MEM_ACK on the same cycle the count reaches TIMEOUT is accepted; no error.
- **Reset mid-instruction:** aborts immediately to FETCH and clears ILLEGAL/BUS_ERR.

## Configuration
- **CU_PERF_CNT_EN defined:**
  - Adds output RETIRED[31:0], reset 0.
  - Increments on every cycle PCW=1, including not-taken branches; wraps 0xFFFFFFFF→0.
  - Frozen in HALT.
- **Undefined:** port absent; no counter logic.

## Test plan
- **Reset/first fetch:** hold RST=0 for 3 cycles, release, MEM_ACK=1 → MEM_REQ=1 the first cycle after release, IRW=1, STATE 0→1.
- **ADD:** OP_CODE=0110011, f3=000, f7=0000000, ack immediate → STATE 0,1,2,4; WB cycle has CRF=1, DWS=00, CALU=000.
- **SUB with bad FUNCT_7:**
  - f7=0100000 → CALU=001.
  - f7=0000001 → ILLEGAL=1, STATE=5, no further MEM_REQ.
- **LW with 3 wait cycles:** MEM state holds MEM_REQ=1 for 4 cycles; WB DWS=01; total 8 cycles.
- **BNE:** OP_CODE=1100011, f3=001 → EXEC has BS=1, OS=1, CEU=010, PCS=01, PCW=1; next state FETCH.
- **Timeout:**
  - MEM_ACK held 0 in FETCH with TIMEOUT=15 → BUS_ERR=1 after 15 cycles, STATE=5.
  - Repeat with MEM_ACK on cycle 15 → no error.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RISC-V control unit: fetch/decode/execute/memory/write-back sequencer with a timed memory handshake.
// Optional CU_PERF_CNT_EN adds a RETIRED counter that counts cycles in which the PC is written.
module rv_multicycle_ctrl #(
    parameter int CALU_W  = 3,
    parameter int WAIT_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [6:0]        OP_CODE,
    input  logic [2:0]        FUNCT_3,
    input  logic [6:0]        FUNCT_7,
    input  logic              MEM_ACK,
    output logic              MEM_REQ,
    output logic              IRW,
    output logic              PCW,
    output logic              CRF,
    output logic [2:0]        CEU,
    output logic [CALU_W-1:0] CALU,
    output logic              CDM,
    output logic [1:0]        PCS,
    output logic [1:0]        DWS,
    output logic              ALUS1,
    output logic              ALUS2,
    output logic              BS,
    output logic              OS,
    output logic              ILLEGAL,
    output logic              BUS_ERR,
    output logic [2:0]        STATE
`ifdef CU_PERF_CNT_EN
    ,
    output logic [31:0]       RETIRED
`endif
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        K_ILL, K_OP, K_OPIMM, K_LW, K_SW, K_LUI, K_JAL, K_JALR, K_BR
    } kind_t;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100, ALU_SRA = 3'b101, ALU_OR  = 3'b110, ALU_SRL = 3'b111;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100;
    localparam logic [WAIT_W:0] TIMEOUT_C = (WAIT_W+1)'(TIMEOUT);

    function automatic kind_t classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        kind_t k;
        k = K_ILL;
        case (op)
            7'b0110011: begin
                if (f7 == 7'b0000000 && f3 != 3'b010 && f3 != 3'b011)
                    k = K_OP;
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    k = K_OP;
            end
            7'b0010011: begin
                case (f3)
                    3'b000, 3'b100, 3'b110, 3'b111: k = K_OPIMM;
                    3'b001: if (f7 == 7'b0000000) k = K_OPIMM;
                    3'b101: if (f7 == 7'b0000000 || f7 == 7'b0100000) k = K_OPIMM;
                    default: k = K_ILL;
                endcase
            end
            7'b0000011: if (f3 == 3'b010) k = K_LW;
            7'b0100011: if (f3 == 3'b010) k = K_SW;
            7'b0110111: k = K_LUI;
            7'b1101111: k = K_JAL;
            7'b1100111: if (f3 == 3'b000) k = K_JALR;
            7'b1100011: if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101) k = K_BR;
            default:    k = K_ILL;
        endcase
        return k;
    endfunction

    // Immediate forms share f3 with register forms; only OP uses f7[5] to pick SUB.
    function automatic logic [2:0] alu_sel(input kind_t k, input logic [2:0] f3, input logic [6:0] f7);
        logic [2:0] a;
        case (f3)
            3'b000:  a = (k == K_OP && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b100:  a = ALU_XOR;
            3'b101:  a = f7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  a = ALU_OR;
            3'b111:  a = ALU_AND;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    state_t            state;
    logic [6:0]        op_q;
    logic [2:0]        f3_q;
    logic [6:0]        f7_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W:0]   wait_inc;
    kind_t             kind_q;
    logic [2:0]        alu;

    assign kind_q   = classify(op_q, f3_q, f7_q);
    assign wait_inc = {1'b0, wait_cnt} + (WAIT_W+1)'(1);
    assign STATE    = state;
    assign CALU     = CALU_W'(alu);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_FETCH;
            op_q     <= '0;
            f3_q     <= '0;
            f7_q     <= '0;
            wait_cnt <= '0;
            ILLEGAL  <= 1'b0;
            BUS_ERR  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every branch below reads the pre-edge state and counter.
            case (state)
                S_FETCH, S_MEM: begin
                    if (MEM_ACK) begin
                        wait_cnt <= '0;
                        if (state == S_FETCH)      state <= S_DECODE;
                        else if (kind_q == K_LW)   state <= S_WB;
                        else                       state <= S_FETCH;
                    end else if (wait_inc == TIMEOUT_C) begin
                        BUS_ERR <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_inc[WAIT_W-1:0];
                    end
                end
                S_DECODE: begin
                    op_q <= OP_CODE;
                    f3_q <= FUNCT_3;
                    f7_q <= FUNCT_7;
                    if (classify(OP_CODE, FUNCT_3, FUNCT_7) == K_ILL) begin
                        ILLEGAL <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    case (kind_q)
                        K_LW, K_SW: state <= S_MEM;
                        K_BR:       state <= S_FETCH;
                        default:    state <= S_WB;
                    endcase
                end
                S_WB: begin
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Handshake strobes (IRW, SW's PCW) follow MEM_ACK within the cycle; the rest is decoded from state.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        MEM_REQ = 1'b0;
        IRW     = 1'b0;
        PCW     = 1'b0;
        CRF     = 1'b0;
        CEU     = IMM_I;
        alu     = ALU_ADD;
        CDM     = 1'b0;
        PCS     = 2'b00;
        DWS     = 2'b00;
        ALUS1   = 1'b0;
        ALUS2   = 1'b0;
        BS      = 1'b0;
        OS      = 1'b0;
        if (RST) begin
            case (state)
                S_FETCH: begin
                    MEM_REQ = 1'b1;
                    IRW     = MEM_ACK;
                end
                S_EXEC: begin
                    case (kind_q)
                        K_OP:    alu = alu_sel(kind_q, f3_q, f7_q);
                        K_OPIMM: begin
                            alu   = alu_sel(kind_q, f3_q, f7_q);
                            ALUS2 = 1'b1;
                        end
                        K_LW:    ALUS2 = 1'b1;
                        K_SW: begin
                            ALUS2 = 1'b1;
                            CEU   = IMM_S;
                        end
                        K_BR: begin
                            BS  = 1'b1;
                            OS  = f3_q[0];
                            CEU = IMM_B;
                            PCS = 2'b01;
                            PCW = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    MEM_REQ = 1'b1;
                    CDM     = (kind_q == K_SW);
                    PCW     = (kind_q == K_SW) && MEM_ACK;
                end
                S_WB: begin
                    CRF = 1'b1;
                    PCW = 1'b1;
                    case (kind_q)
                        K_LW:    DWS = 2'b01;
                        K_LUI: begin
                            DWS = 2'b11;
                            CEU = IMM_U;
                        end
                        K_JAL: begin
                            DWS = 2'b10;
                            PCS = 2'b11;
                            CEU = IMM_J;
                        end
                        K_JALR: begin
                            DWS = 2'b10;
                            PCS = 2'b10;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifdef CU_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)     RETIRED <= '0;
        else if (PCW) RETIRED <= RETIRED + 32'd1;
    end
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: each cycle's expected control bundle is queued as stimulus is
// driven and compared against the sampled outputs on the falling edge.
module tb_rv_multicycle_ctrl;

    localparam int CALU_W  = 3;
    localparam int WAIT_W  = 4;
    localparam int TIMEOUT = 15;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [6:0]        OP_CODE = '0;
    logic [2:0]        FUNCT_3 = '0;
    logic [6:0]        FUNCT_7 = '0;
    logic              MEM_ACK = 1'b0;
    logic              MEM_REQ, IRW, PCW, CRF, CDM, ALUS1, ALUS2, BS, OS, ILLEGAL, BUS_ERR;
    logic [2:0]        CEU, STATE;
    logic [CALU_W-1:0] CALU;
    logic [1:0]        PCS, DWS;

    rv_multicycle_ctrl #(.CALU_W(CALU_W), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .OP_CODE(OP_CODE), .FUNCT_3(FUNCT_3), .FUNCT_7(FUNCT_7),
        .MEM_ACK(MEM_ACK), .MEM_REQ(MEM_REQ), .IRW(IRW), .PCW(PCW), .CRF(CRF), .CEU(CEU),
        .CALU(CALU), .CDM(CDM), .PCS(PCS), .DWS(DWS), .ALUS1(ALUS1), .ALUS2(ALUS2),
        .BS(BS), .OS(OS), .ILLEGAL(ILLEGAL), .BUS_ERR(BUS_ERR), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req, irw, pcw, crf;
        logic [2:0] ceu, calu;
        logic       cdm;
        logic [1:0] pcs, dws;
        logic       alus1, alus2, bs, os, illegal, bus_err;
    } obs_t;

    obs_t  obs;
    assign obs = {STATE, MEM_REQ, IRW, PCW, CRF, CEU, CALU, CDM, PCS, DWS,
                  ALUS1, ALUS2, BS, OS, ILLEGAL, BUS_ERR};

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic obs_t z(input logic [2:0] s);
        obs_t r;
        r       = '0;
        r.state = s;
        return r;
    endfunction

    // Called at posedge+1: drive ack, queue expectation, compare on the falling edge.
    task automatic step(input logic ack, input obs_t e, input string tag);
        obs_t  want;
        string t;
        MEM_ACK = ack;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge CLK);
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        check(t, {8'h00, obs}, {8'h00, want});
        @(posedge CLK);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        OP_CODE = op;
        FUNCT_3 = f3;
        FUNCT_7 = f7;
    endtask

    task automatic fetch(input int waits, input string name);
        obs_t e;
        e         = z(S_F);
        e.mem_req = 1'b1;
        for (int i = 0; i < waits; i++) step(1'b0, e, {name, "_fwait"});
        e.irw = 1'b1;
        step(1'b1, e, {name, "_fetch"});
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [2:0] calu, input logic imm, input string name);
        obs_t e;
        set_instr(op, f3, f7);
        fetch(0, name);
        step(1'b1, z(S_D), {name, "_dec"});
        e       = z(S_E);
        e.calu  = calu;
        e.alus2 = imm;
        step(1'b0, e, {name, "_exec"});
        e     = z(S_W);
        e.crf = 1'b1;
        e.pcw = 1'b1;
        step(1'b0, e, {name, "_wb"});
    endtask

    task automatic run_jump(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] pcs,
                            input logic [1:0] dws, input logic [2:0] ceu, input string name);
        obs_t e;
        set_instr(op, f3, 7'h00);
        fetch(0, name);
        step(1'b0, z(S_D), {name, "_dec"});
        step(1'b0, z(S_E), {name, "_exec"});
        e     = z(S_W);
        e.crf = 1'b1;
        e.pcw = 1'b1;
        e.pcs = pcs;
        e.dws = dws;
        e.ceu = ceu;
        step(1'b0, e, {name, "_wb"});
    endtask

    task automatic run_branch(input logic [2:0] f3, input string name);
        obs_t e;
        set_instr(7'b1100011, f3, 7'h00);
        fetch(0, name);
        step(1'b0, z(S_D), {name, "_dec"});
        e     = z(S_E);
        e.bs  = 1'b1;
        e.os  = f3[0];
        e.ceu = 3'b010;
        e.pcs = 2'b01;
        e.pcw = 1'b1;
        step(1'b0, e, {name, "_exec"});
    endtask

    task automatic pulse_reset(input string name);
        RST = 1'b0;
        step(1'b1, z(S_F), {name, "_rst"});
        RST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        obs_t e;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, z(S_F), "reset_hold");
        RST = 1'b1;

        run_alu(7'b0110011, 3'b000, 7'b0000000, 3'b000, 1'b0, "add");
        run_alu(7'b0110011, 3'b000, 7'b0100000, 3'b001, 1'b0, "sub");
        run_alu(7'b0110011, 3'b111, 7'b0000000, 3'b010, 1'b0, "and");
        run_alu(7'b0110011, 3'b100, 7'b0000000, 3'b011, 1'b0, "xor");
        run_alu(7'b0110011, 3'b001, 7'b0000000, 3'b100, 1'b0, "sll");
        run_alu(7'b0110011, 3'b101, 7'b0100000, 3'b101, 1'b0, "sra");
        run_alu(7'b0110011, 3'b110, 7'b0000000, 3'b110, 1'b0, "or");
        run_alu(7'b0110011, 3'b101, 7'b0000000, 3'b111, 1'b0, "srl");
        run_alu(7'b0010011, 3'b000, 7'b0100000, 3'b000, 1'b1, "addi");
        run_alu(7'b0010011, 3'b111, 7'b0000011, 3'b010, 1'b1, "andi");
        run_alu(7'b0010011, 3'b110, 7'b0000000, 3'b110, 1'b1, "ori");
        run_alu(7'b0010011, 3'b001, 7'b0000000, 3'b100, 1'b1, "slli");
        run_alu(7'b0010011, 3'b101, 7'b0100000, 3'b101, 1'b1, "srai");

        // LW with three memory wait cycles: 8 cycles in total.
        set_instr(7'b0000011, 3'b010, 7'h00);
        fetch(0, "lw");
        step(1'b0, z(S_D), "lw_dec");
        e       = z(S_E);
        e.alus2 = 1'b1;
        step(1'b0, e, "lw_exec");
        e         = z(S_M);
        e.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, e, "lw_mwait");
        step(1'b1, e, "lw_mack");
        e     = z(S_W);
        e.crf = 1'b1;
        e.pcw = 1'b1;
        e.dws = 2'b01;
        step(1'b0, e, "lw_wb");

        // SW with fetch waits and one memory wait.
        set_instr(7'b0100011, 3'b010, 7'h00);
        fetch(2, "sw");
        step(1'b0, z(S_D), "sw_dec");
        e       = z(S_E);
        e.alus2 = 1'b1;
        e.ceu   = 3'b001;
        step(1'b0, e, "sw_exec");
        e         = z(S_M);
        e.mem_req = 1'b1;
        e.cdm     = 1'b1;
        step(1'b0, e, "sw_mwait");
        e.pcw = 1'b1;
        step(1'b1, e, "sw_mack");

        run_branch(3'b001, "bne");
        run_branch(3'b100, "blt");
        run_jump(7'b1101111, 3'b000, 2'b11, 2'b10, 3'b100, "jal");
        run_jump(7'b1100111, 3'b000, 2'b10, 2'b10, 3'b000, "jalr");
        run_jump(7'b0110111, 3'b000, 2'b00, 2'b11, 3'b011, "lui");

        // Reset in the middle of an LW aborts to FETCH.
        set_instr(7'b0000011, 3'b010, 7'h00);
        fetch(0, "abort");
        step(1'b0, z(S_D), "abort_dec");
        pulse_reset("abort");

        // Illegal FUNCT_7 halts; MEM_ACK in HALT is ignored.
        set_instr(7'b0110011, 3'b000, 7'b0000001);
        fetch(0, "ill");
        step(1'b0, z(S_D), "ill_dec");
        e         = z(S_H);
        e.illegal = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, e, "ill_halt");
        pulse_reset("ill");

        set_instr(7'b0000011, 3'b000, 7'h00);
        fetch(0, "lb");
        step(1'b0, z(S_D), "lb_dec");
        step(1'b0, e, "lb_halt");
        pulse_reset("lb");

        // Ack on the last permitted wait cycle is accepted.
        run_alu(7'b0110011, 3'b000, 7'b0000000, 3'b000, 1'b0, "warm");
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        fetch(TIMEOUT - 1, "edge");
        step(1'b0, z(S_D), "edge_dec");
        step(1'b0, z(S_E), "edge_exec");
        e     = z(S_W);
        e.crf = 1'b1;
        e.pcw = 1'b1;
        step(1'b0, e, "edge_wb");

        // TIMEOUT cycles without ack end in a bus-error halt.
        e         = z(S_F);
        e.mem_req = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) step(1'b0, e, "to_wait");
        e         = z(S_H);
        e.bus_err = 1'b1;
        step(1'b1, e, "to_halt");
        step(1'b0, e, "to_halt2");
        pulse_reset("to");
        fetch(0, "after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
